// File: rtl/conversor_bin_bcd_if.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd_if
// Purpose : groups the start/result handshake of the binary-to-BCD converter.
// Signals : iniciar         start request (master -> slave)
//           registradorin   unsigned binary operand, LARGURA bits (master -> slave)
//           registradorout  BCD result, 4*DIGITOS bits, digit 0 in [3:0]
//           ocupado         conversion in progress
//           pronto          one-cycle pulse when registradorout updates
//           estouro         last result exceeded 10^DIGITOS-1
// Modports: master (requester / testbench), slave (converter)
// -----------------------------------------------------------------------------
interface conversor_bin_bcd_if #(
   parameter int LARGURA = 14,
   parameter int DIGITOS = 4
);
   logic                   iniciar;
   logic [LARGURA-1:0]     registradorin;
   logic [4*DIGITOS-1:0]   registradorout;
   logic                   ocupado;
   logic                   pronto;
   logic                   estouro;

   modport master (
      output iniciar, registradorin,
      input  registradorout, ocupado, pronto, estouro
   );

   modport slave (
      input  iniciar, registradorin,
      output registradorout, ocupado, pronto, estouro
   );
endinterface

// File: rtl/conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd
// Purpose : iterative binary-to-BCD converter (double dabble), one input bit
//           per clock, MSB first. A conversion takes LARGURA shift cycles plus
//           one FIM cycle; results saturate to all 9s on overflow.
// Ports   : clock  single clock, rising edge
//           reset  synchronous, active-high
//           bus    conversor_bin_bcd_if.slave (iniciar, registradorin,
//                  registradorout, ocupado, pronto, estouro)
// Params  : LARGURA (4..32) input width, DIGITOS (1..10) output digits
// Macro   : CONVERSOR_BIN_BCD_ZERO_BLANK_EN -- when defined, leading zero
//           digits above digit 0 are shown as 4'hF (saturated results excluded)
// -----------------------------------------------------------------------------
module conversor_bin_bcd #(
   parameter int LARGURA = 14,
   parameter int DIGITOS = 4
) (
   input  logic               clock,
   input  logic               reset,
   conversor_bin_bcd_if.slave bus
);

   // LARGURA bits never need more than ceil(LARGURA/3) decimal digits since
   // 2^3 < 10; the scratch is also at least DIGITOS wide so the output slice
   // always exists.
   localparam int SCR_MIN = (LARGURA + 2) / 3;
   localparam int SCR_DIG = (SCR_MIN > DIGITOS) ? SCR_MIN : DIGITOS;
   localparam int SCR_W   = 4 * SCR_DIG;
   localparam int OUT_W   = 4 * DIGITOS;
   localparam int CNT_W   = $clog2(LARGURA + 1);

   typedef enum logic [1:0] {
      OCIOSO,
      DESLOCA,
      FIM
   } estado_t;

   estado_t            state_q,   state_d;
   logic [LARGURA-1:0] bin_q,     bin_d;
   logic [SCR_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [OUT_W-1:0]   out_q,     out_d;
   logic               pronto_q,  pronto_d;
   logic               estouro_q, estouro_d;

   logic [SCR_W-1:0]   ajustado;
   logic               excede;
`ifdef CONVERSOR_BIN_BCD_ZERO_BLANK_EN
   logic               lider;
`endif

   // Add-3 correction: any digit >=5 would become >=10 after the shift.
   always_comb begin
      ajustado = scratch_q;
      for (int k = 0; k < SCR_DIG; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            ajustado[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Any nonzero digit beyond the visible ones means value >= 10^DIGITOS.
   always_comb begin
      excede = 1'b0;
      for (int k = DIGITOS; k < SCR_DIG; k++) begin
         if (scratch_q[4*k +: 4] != 4'h0) begin
            excede = 1'b1;
         end
      end
   end

   // Next-state and datapath
   // NOTE: every variable gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      pronto_d  = 1'b0;
      estouro_d = estouro_q;
`ifdef CONVERSOR_BIN_BCD_ZERO_BLANK_EN
      lider     = 1'b1;
`endif

      unique case (state_q)
         OCIOSO: begin
            if (bus.iniciar) begin
               bin_d     = bus.registradorin;
               scratch_d = '0;
               cnt_d     = CNT_W'(LARGURA);
               state_d   = DESLOCA;
            end
         end

         DESLOCA: begin
            // Shift the corrected scratch left, bringing in the next MSB.
            scratch_d = SCR_W'({ajustado, bin_q[LARGURA-1]});
            bin_d     = {bin_q[LARGURA-2:0], 1'b0};
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIM;
            end
         end

         FIM: begin
            pronto_d  = 1'b1;
            estouro_d = excede;
            if (excede) begin
               out_d = {DIGITOS{4'h9}};
            end else begin
               out_d = scratch_q[OUT_W-1:0];
`ifdef CONVERSOR_BIN_BCD_ZERO_BLANK_EN
               // Blank from the top down until the first nonzero digit.
               for (int k = DIGITOS - 1; k >= 1; k--) begin
                  if (lider && (out_d[4*k +: 4] == 4'h0)) begin
                     out_d[4*k +: 4] = 4'hF;
                  end else begin
                     lider = 1'b0;
                  end
               end
`endif
            end
            state_d = OCIOSO;
         end

         default: state_d = OCIOSO;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; reset is synchronous and overrides iniciar.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= OCIOSO;
         bin_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         out_q     <= '0;
         pronto_q  <= 1'b0;
         estouro_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         pronto_q  <= pronto_d;
         estouro_q <= estouro_d;
      end
   end

   assign bus.registradorout = out_q;
   assign bus.pronto         = pronto_q;
   assign bus.estouro        = estouro_q;
   assign bus.ocupado        = (state_q != OCIOSO);

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// tb_conversor_bin_bcd
// Purpose : self-checking bench for conversor_bin_bcd at LARGURA=14, DIGITOS=4.
//           Expected results come from a decimal-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_conversor_bin_bcd;

   localparam int L     = 14;
   localparam int D     = 4;
   localparam int LAT   = L + 1;   // pronto seen after edge L+1 (acceptance = edge 0)
   localparam int LIMIT = 60;      // cycle budget while waiting for pronto

   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   conversor_bin_bcd_if #(.LARGURA(L), .DIGITOS(D)) bif ();

   conversor_bin_bcd #(.LARGURA(L), .DIGITOS(D)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {estouro, registradorout} from plain decimal arithmetic.
   function automatic logic [4*D:0] model(input int unsigned v);
      logic [4*D-1:0] r;
      int unsigned    x;
      int unsigned    lim;
      bit             lead;
      lim = 1;
      for (int k = 0; k < D; k++) lim = lim * 10;
      if (v >= lim) return {1'b1, {D{4'h9}}};
      x = v;
      r = '0;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
`ifdef CONVERSOR_BIN_BCD_ZERO_BLANK_EN
      lead = 1'b1;
      for (int k = D - 1; k >= 1; k--) begin
         if (lead && r[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
         else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
      return {lead & 1'b0, r};
   endfunction

   // Called #1 after the accepting edge. Optionally re-requests a start with
   // value 42 at cycle inj to show it is ignored. Returns latency and the
   // number of sampled cycles with ocupado high.
   task automatic wait_result(input int inj, output int lat, output int n_ocup);
      lat    = -1;
      n_ocup = bif.ocupado ? 1 : 0;
      for (int i = 1; i <= LIMIT && lat < 0; i++) begin
         if (i == inj) begin
            bif.iniciar       = 1'b1;
            bif.registradorin = 14'd42;
         end else begin
            bif.iniciar = 1'b0;
         end
         @(posedge clock); #1;
         if (bif.ocupado) n_ocup++;
         if (bif.pronto)  lat = i;
      end
      bif.iniciar = 1'b0;
   endtask

   task automatic run_conv(input string tag, input int unsigned v, input int inj);
      int lat, n_ocup;
      logic [4*D:0] exp;
      exp = model(v);
      @(negedge clock);
      bif.registradorin = L'(v);
      bif.iniciar       = 1'b1;
      @(posedge clock); #1;
      bif.iniciar = 1'b0;
      wait_result(inj, lat, n_ocup);
      check({tag, ".latency"}, 32'(lat), 32'(LAT));
      check({tag, ".ocupado_cycles"}, 32'(n_ocup), 32'(LAT));
      check({tag, ".out"}, 32'(bif.registradorout), 32'(exp[4*D-1:0]));
      check({tag, ".estouro"}, 32'(bif.estouro), 32'(exp[4*D]));
   endtask

   initial begin
      int lat, n_ocup, extra;
      logic [4*D:0] exp;
      logic [4*D-1:0] held;

      // Reset with iniciar asserted: reset must win.
      reset             = 1'b1;
      bif.iniciar       = 1'b1;
      bif.registradorin = 14'd777;
      repeat (2) @(posedge clock);
      #1;
      check("reset.out", 32'(bif.registradorout), 32'h0);
      check("reset.ocupado", 32'(bif.ocupado), 32'h0);
      check("reset.pronto", 32'(bif.pronto), 32'h0);
      check("reset.estouro", 32'(bif.estouro), 32'h0);
      bif.iniciar = 1'b0;
      reset       = 1'b0;
      repeat (2) @(posedge clock);

      // Directed values, including decimal boundaries and overflow.
      run_conv("v1234", 1234, -1);
      run_conv("v0", 0, -1);
      run_conv("v9", 9, -1);
      run_conv("v10", 10, -1);
      run_conv("v9999", 9999, -1);
      run_conv("v10000", 10000, -1);
      run_conv("v16383", 16383, -1);
      run_conv("v5", 5, -1);
      run_conv("v42", 42, -1);

      // Start accepted in the pronto cycle (back-to-back).
      run_conv("b2b_a", 321, -1);
      bif.registradorin = 14'd8765;
      bif.iniciar       = 1'b1;
      @(posedge clock); #1;
      bif.iniciar = 1'b0;
      check("b2b.pronto_pulse", 32'(bif.pronto), 32'h0);
      check("b2b.accepted", 32'(bif.ocupado), 32'h1);
      wait_result(-1, lat, n_ocup);
      exp = model(8765);
      check("b2b.latency", 32'(lat), 32'(LAT));
      check("b2b.out", 32'(bif.registradorout), 32'(exp[4*D-1:0]));

      // Start request mid-conversion is ignored.
      run_conv("midreq", 1234, 5);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (bif.pronto) extra++;
      end
      check("midreq.no_second_pronto", 32'(extra), 32'h0);
      check("midreq.out_held", 32'(bif.registradorout), 32'(model(1234)));

      // Reset at cycle 7 of a conversion, after an overflowed result.
      run_conv("pre_abort", 10000, -1);
      @(negedge clock);
      bif.registradorin = 14'd1234;
      bif.iniciar       = 1'b1;
      @(posedge clock); #1;
      bif.iniciar = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort.out", 32'(bif.registradorout), 32'h0);
      check("abort.estouro", 32'(bif.estouro), 32'h0);
      check("abort.ocupado", 32'(bif.ocupado), 32'h0);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (bif.pronto) extra++;
      end
      check("abort.no_pronto", 32'(extra), 32'h0);
      run_conv("after_abort", 4321, -1);

      // Randomised values against the model, with pulse width and hold checks.
      for (int n = 0; n < 16; n++) begin
         int unsigned v;
         v = $urandom_range(0, (1 << L) - 1);
         run_conv($sformatf("rnd%0d", n), v, -1);
         held = bif.registradorout;
         repeat (3) @(posedge clock);
         #1;
         check("rnd.pronto_one_cycle", 32'(bif.pronto), 32'h0);
         check("rnd.out_hold", 32'(bif.registradorout), 32'(held));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
